// File: rtl/bsg_lane_compactor.sv
// Lane compactor: takes a word of els_p lanes plus a lane-valid mask and
// emits the valid lanes one per cycle, lowest lane first, on a valid/yumi port.
module bsg_lane_compactor #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [els_p*width_p-1:0]   data_i,
  input  logic [els_p-1:0]           mask_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(els_p)-1:0]   idx_o,
  output logic                       last_o,
  input  logic                       yumi_i
);

  localparam int idx_w_lp = $clog2(els_p);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                     state_q, state_d;
  logic [els_p*width_p-1:0]   data_q, data_d;
  logic [els_p-1:0]           rem_q, rem_d;
  logic [els_p-1:0]           rem_lsb;
  logic [idx_w_lp-1:0]        idx;
  logic [width_p-1:0]         lanes [els_p];
  logic                       emit, onehot, accept;

  for (genvar gi = 0; gi < els_p; gi++) begin : g_lane
    assign lanes[gi] = data_q[gi*width_p +: width_p];
  end

  // Isolate the lowest remaining lane; the loop runs high to low so the
  // lowest set bit is the final assignment.
  assign rem_lsb = rem_q & (~rem_q + 1'b1);

  always_comb begin
    idx = '0;
    for (int k = els_p - 1; k >= 0; k--) begin
      if (rem_q[k]) idx = idx_w_lp'(k);
    end
  end

  assign emit   = (state_q == EMIT);
  assign onehot = (rem_q != '0) && ((rem_q & (rem_q - 1'b1)) == '0);

  assign v_o     = emit;
  assign last_o  = emit & onehot;
  assign idx_o   = emit ? idx : '0;
  assign data_o  = emit ? lanes[idx] : '0;
  // Accepting on the final yumi lets back-to-back words stream without a bubble.
  assign ready_o = ~emit | (onehot & yumi_i);
  assign accept  = v_i & ready_o;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    if (emit && yumi_i) begin
      rem_d = rem_q & ~rem_lsb;
      if (onehot) state_d = IDLE;
    end
    if (accept) begin
      if (mask_i != '0) begin
        data_d  = data_i;
        rem_d   = mask_i;
        state_d = EMIT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(yumi_i && !v_o));

endmodule

// File: tb/tb_bsg_lane_compactor.sv
// Directed and scoreboarded random checks for bsg_lane_compactor (4 lanes x 8 bits).
module tb_bsg_lane_compactor;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic [31:0] data_i;
  logic [3:0]  mask_i;
  logic        ready_o;
  logic        v_o;
  logic [7:0]  data_o;
  logic [1:0]  idx_o;
  logic        last_o;
  logic        yumi_i;

  int n_checks = 0;
  int n_errors = 0;

  bsg_lane_compactor #(.width_p(8), .els_p(4)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .data_i    (data_i),
    .mask_i    (mask_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .idx_o     (idx_o),
    .last_o    (last_o),
    .yumi_i    (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive inputs for the current cycle and let combinational outputs settle.
  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] m, input logic y);
    v_i = v; data_i = d; mask_i = m; yumi_i = y;
    #1;
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic [1:0] i, input logic l, input logic r);
    check({tag, "_v"},     v_o,     v);
    check({tag, "_data"},  data_o,  d);
    check({tag, "_idx"},   idx_o,   i);
    check({tag, "_last"},  last_o,  l);
    check({tag, "_ready"}, ready_o, r);
    $display("cyc %s: v=%0d data=%02h idx=%0d last=%0d ready=%0d", tag, v_o, data_o, idx_o, last_o, ready_o);
  endtask

  int          q_idx[$];
  logic [7:0]  q_dat[$];

  initial begin
    reset_n_i = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    #3;
    check_out("reset", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    #4;
    reset_n_i = 1'b1;

    // Sparse mask 1010, first accept right after reset release.
    drive(1'b1, 32'h44332211, 4'b1010, 1'b0);
    check_out("m1010_c0", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    nxt();
    drive(1'b0, 32'h0, 4'h0, 1'b1);
    check_out("m1010_c1", 1'b1, 8'h22, 2'd1, 1'b0, 1'b0);
    nxt();
    check_out("m1010_c2", 1'b1, 8'h44, 2'd3, 1'b1, 1'b1);
    nxt();
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    check_out("m1010_c3", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Back-to-back words 0001 then 1111 with no bubble.
    drive(1'b1, 32'hDDCCBBAA, 4'b0001, 1'b0);
    check_out("b2b_c0", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    nxt();
    drive(1'b1, 32'h88776655, 4'b1111, 1'b1);
    check_out("b2b_c1", 1'b1, 8'hAA, 2'd0, 1'b1, 1'b1);
    nxt();
    drive(1'b0, 32'h0, 4'h0, 1'b1);
    check_out("b2b_c2", 1'b1, 8'h55, 2'd0, 1'b0, 1'b0);
    nxt();
    check_out("b2b_c3", 1'b1, 8'h66, 2'd1, 1'b0, 1'b0);
    nxt();
    check_out("b2b_c4", 1'b1, 8'h77, 2'd2, 1'b0, 1'b0);
    nxt();
    check_out("b2b_c5", 1'b1, 8'h88, 2'd3, 1'b1, 1'b1);
    nxt();
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    check_out("b2b_c6", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Backpressure on mask 0110 while another word is offered.
    drive(1'b1, 32'h44332211, 4'b0110, 1'b0);
    nxt();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'hEE000000, 4'b1000, 1'b0);
      check_out($sformatf("hold_c%0d", c), 1'b1, 8'h22, 2'd1, 1'b0, 1'b0);
      nxt();
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1);
    check_out("hold_c3", 1'b1, 8'h22, 2'd1, 1'b0, 1'b0);
    nxt();
    check_out("hold_c4", 1'b1, 8'h33, 2'd2, 1'b1, 1'b1);
    nxt();
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    check_out("hold_c5", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Empty mask is consumed with no output.
    drive(1'b1, 32'h12345678, 4'b0000, 1'b0);
    check_out("zero_c0", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    nxt();
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    check_out("zero_c1", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    nxt();
    check_out("zero_c2", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a word.
    drive(1'b1, 32'h44332211, 4'b1111, 1'b0);
    nxt();
    drive(1'b0, 32'h0, 4'h0, 1'b1);
    check_out("rst_c1", 1'b1, 8'h11, 2'd0, 1'b0, 1'b0);
    nxt();
    check_out("rst_c2", 1'b1, 8'h22, 2'd1, 1'b0, 1'b0);
    reset_n_i = 1'b0;
    yumi_i = 1'b0;
    #1;
    check_out("rst_async", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    nxt();
    reset_n_i = 1'b1;
    drive(1'b1, 32'h99000000, 4'b1000, 1'b0);
    check_out("rst_post_c0", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    nxt();
    drive(1'b0, 32'h0, 4'h0, 1'b1);
    check_out("rst_post_c1", 1'b1, 8'h99, 2'd3, 1'b1, 1'b1);
    nxt();
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    check_out("rst_post_c2", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Random masks and backpressure against a scoreboard.
    begin
      logic [3:0]  cur_mask;
      logic [31:0] cur_data;
      logic        have_word, pop, acc, exp_ready;
      int sent, cyc, total_exp, total_got;
      have_word = 1'b0; sent = 0; cyc = 0; total_exp = 0; total_got = 0;
      cur_mask = '0; cur_data = '0;
      while ((sent < 40 || have_word || q_idx.size() != 0) && cyc < 3000) begin
        if (!have_word && sent < 40) begin
          cur_mask  = 4'($urandom_range(0, 15));
          cur_data  = $urandom;
          have_word = 1'b1;
        end
        drive(have_word, cur_data, cur_mask, v_o && ($urandom_range(0, 2) != 0));
        check("rnd_v", v_o, q_idx.size() != 0);
        exp_ready = (q_idx.size() == 0) || (q_idx.size() == 1 && yumi_i);
        check("rnd_ready", ready_o, exp_ready);
        if (v_o && q_idx.size() != 0) begin
          check("rnd_idx",  idx_o,  q_idx[0]);
          check("rnd_data", data_o, q_dat[0]);
          check("rnd_last", last_o, q_idx.size() == 1);
          if (yumi_i)
            $display("rnd elem: idx=%0d data=%02h last=%0d", idx_o, data_o, last_o);
        end
        pop = v_o && yumi_i && q_idx.size() != 0;
        acc = v_i && exp_ready;
        nxt();
        cyc++;
        if (pop) begin
          void'(q_idx.pop_front());
          void'(q_dat.pop_front());
          total_got++;
        end
        if (acc) begin
          for (int k = 0; k < 4; k++) begin
            if (cur_mask[k]) begin
              q_idx.push_back(k);
              q_dat.push_back(cur_data[k*8 +: 8]);
            end
          end
          total_exp += $countones(cur_mask);
          have_word = 1'b0;
          sent++;
        end
      end
      drive(1'b0, 32'h0, 4'h0, 1'b0);
      check("rnd_timeout", cyc < 3000, 1'b1);
      check("rnd_count", total_got, total_exp);
      $display("rnd summary: words=%0d elements=%0d expected=%0d", sent, total_got, total_exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
